// File: rtl/amber_stg_ex_pkg.sv
//== amber_stg_ex_pkg -- shared widths, opcodes, cc codes and helpers ==
//== rev 1.0                                                          ==
`default_nettype none

package amber_stg_ex_pkg;

  localparam int ADDR_W = 48;
  localparam int DATA_W = 24;
  localparam int OPC_W  = 8;
  localparam int CC_W   = 4;
  localparam int GP_W   = 4;
  localparam int AR_W   = 2;
  localparam int SR_W   = 2;

  localparam logic [OPC_W-1:0] OP_NOP   = 8'h00;
  localparam logic [OPC_W-1:0] OP_MOV   = 8'h01;
  localparam logic [OPC_W-1:0] OP_ADD   = 8'h02;
  localparam logic [OPC_W-1:0] OP_SUB   = 8'h03;
  localparam logic [OPC_W-1:0] OP_AND   = 8'h04;
  localparam logic [OPC_W-1:0] OP_OR    = 8'h05;
  localparam logic [OPC_W-1:0] OP_XOR   = 8'h06;
  localparam logic [OPC_W-1:0] OP_SHL   = 8'h07;
  localparam logic [OPC_W-1:0] OP_SHR   = 8'h08;
  localparam logic [OPC_W-1:0] OP_SAR   = 8'h09;
  localparam logic [OPC_W-1:0] OP_CMP   = 8'h0A;
  localparam logic [OPC_W-1:0] OP_LD    = 8'h10;
  localparam logic [OPC_W-1:0] OP_ST    = 8'h11;
  localparam logic [OPC_W-1:0] OP_ADDA  = 8'h18;
  localparam logic [OPC_W-1:0] OP_MOVA  = 8'h19;
  localparam logic [OPC_W-1:0] OP_SRMOV = 8'h20;
  localparam logic [OPC_W-1:0] OP_BCC   = 8'h30;
  localparam logic [OPC_W-1:0] OP_JCC   = 8'h31;
  localparam logic [OPC_W-1:0] OP_BAL   = 8'h32;
  localparam logic [OPC_W-1:0] OP_SRET  = 8'h33;

  localparam logic [CC_W-1:0] CC_AL  = 4'h0;
  localparam logic [CC_W-1:0] CC_EQ  = 4'h1;
  localparam logic [CC_W-1:0] CC_NE  = 4'h2;
  localparam logic [CC_W-1:0] CC_LT  = 4'h3;
  localparam logic [CC_W-1:0] CC_GE  = 4'h4;
  localparam logic [CC_W-1:0] CC_LTU = 4'h5;
  localparam logic [CC_W-1:0] CC_GEU = 4'h6;

  localparam logic [SR_W-1:0] SR_LR = 2'd1;

  typedef enum logic [3:0] {
    ALU_MOV, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
    ALU_XOR, ALU_SHL, ALU_SHR, ALU_SAR
  } alu_op_e;

  // C is the carry out for ADD and the borrow for SUB/CMP.
  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [OPC_W-1:0]  opc;
    logic [GP_W-1:0]   tgt_gp;
    logic              tgt_gp_we;
    logic [SR_W-1:0]   tgt_sr;
    logic              tgt_sr_we;
    logic [AR_W-1:0]   tgt_ar;
    logic              tgt_ar_we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] result;
    logic [ADDR_W-1:0] ar_result;
    logic [ADDR_W-1:0] sr_result;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_pc;
  } ex_mem_t;

  function automatic logic [ADDR_W-1:0] sext16(input logic [15:0] x);
    return {{32{x[15]}}, x};
  endfunction

  function automatic logic [ADDR_W-1:0] sext14(input logic [13:0] x);
    return {{34{x[13]}}, x};
  endfunction

  function automatic logic [ADDR_W-1:0] sext12(input logic [11:0] x);
    return {{36{x[11]}}, x};
  endfunction

  function automatic logic cc_holds(input logic [CC_W-1:0] cc, input flags_t f);
    logic ok;
    case (cc)
      CC_AL:   ok = 1'b1;
      CC_EQ:   ok = f.z;
      CC_NE:   ok = !f.z;
      CC_LT:   ok = f.n ^ f.v;
      CC_GE:   ok = !(f.n ^ f.v);
      CC_LTU:  ok = f.c;
      CC_GEU:  ok = !f.c;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/amber_stg_ex_alu.sv
//== amber_stg_ex_alu -- combinational 24-bit ALU with Z/N/C/V generation ==
//== rev 1.0                                                             ==
`default_nettype none

module amber_stg_ex_alu
  import amber_stg_ex_pkg::*;
(
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output flags_t            flags
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;
  logic            big_shift;

  assign sum       = {1'b0, a} + {1'b0, b};
  assign diff      = {1'b0, a} - {1'b0, b};
  assign big_shift = (b >= 24'd24);

  always_comb begin
    result  = '0;
    flags.c = 1'b0;
    flags.v = 1'b0;
    case (op)
      ALU_MOV: result = b;
      ALU_ADD: begin
        result  = sum[DATA_W-1:0];
        flags.c = sum[DATA_W];
        flags.v = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        result  = diff[DATA_W-1:0];
        flags.c = diff[DATA_W];
        flags.v = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SHL: result = big_shift ? '0 : (a << b[4:0]);
      ALU_SHR: result = big_shift ? '0 : (a >> b[4:0]);
      // Oversized arithmetic shifts saturate to the sign fill.
      ALU_SAR: result = big_shift ? {DATA_W{a[DATA_W-1]}} : $unsigned($signed(a) >>> b[4:0]);
      default: result = '0;
    endcase
    flags.z = (result == '0);
    flags.n = result[DATA_W-1];
  end

endmodule

`default_nettype wire

// File: rtl/amber_stg_ex.sv
//== amber_stg_ex -- Amber execute stage: ALU, AR/SR ops, cc and branches ==
//== rev 1.0                                                             ==
`default_nettype none

module amber_stg_ex
  import amber_stg_ex_pkg::*;
(
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic [ADDR_W-1:0] iw_pc,
  input  logic [DATA_W-1:0] iw_instr,
  input  logic [OPC_W-1:0]  iw_opc,
  input  logic              iw_sgn_en,
  input  logic              iw_imm_en,
  input  logic [15:0]       iw_imm16_val,
  input  logic [13:0]       iw_imm14_val,
  input  logic [11:0]       iw_imm12_val,
  input  logic [9:0]        iw_imm10_val,
  input  logic [CC_W-1:0]   iw_cc,
  input  logic [GP_W-1:0]   iw_tgt_gp,
  input  logic              iw_tgt_gp_we,
  input  logic [SR_W-1:0]   iw_tgt_sr,
  input  logic              iw_tgt_sr_we,
  input  logic [AR_W-1:0]   iw_tgt_ar,
  input  logic [GP_W-1:0]   iw_src_gp,
  input  logic [AR_W-1:0]   iw_src_ar,
  input  logic [SR_W-1:0]   iw_src_sr,
  input  logic [DATA_W-1:0] iw_src_gp_val,
  input  logic [DATA_W-1:0] iw_tgt_gp_val,
  input  logic [ADDR_W-1:0] iw_src_ar_val,
  input  logic [ADDR_W-1:0] iw_tgt_ar_val,
  input  logic [ADDR_W-1:0] iw_src_sr_val,
  input  logic [ADDR_W-1:0] iw_tgt_sr_val,
  input  logic              iw_flush,
  input  logic              iw_stall,
  output logic [ADDR_W-1:0] ow_pc,
  output logic [DATA_W-1:0] ow_instr,
  output logic [OPC_W-1:0]  ow_opc,
  output logic [GP_W-1:0]   ow_tgt_gp,
  output logic              ow_tgt_gp_we,
  output logic [SR_W-1:0]   ow_tgt_sr,
  output logic              ow_tgt_sr_we,
  output logic [AR_W-1:0]   ow_tgt_ar,
  output logic              ow_tgt_ar_we,
  output logic [ADDR_W-1:0] ow_addr,
  output logic [DATA_W-1:0] ow_result,
  output logic [ADDR_W-1:0] ow_ar_result,
  output logic [ADDR_W-1:0] ow_sr_result,
  output logic              ow_branch_taken,
  output logic [ADDR_W-1:0] ow_branch_pc
);

  ex_mem_t           out_q;
  ex_mem_t           nxt;
  flags_t            flags_q;
  flags_t            alu_flags;
  alu_op_e           alu_op;
  logic              upd_flags;
  logic              cc_ok;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_result;
  logic [ADDR_W-1:0] ls_addr;
  logic              unused_inputs;

  // Source indices only matter to forwarding upstream.
  assign unused_inputs = ^{iw_src_gp, iw_src_ar, iw_src_sr, iw_imm10_val};

  assign imm_ext = iw_sgn_en ? {{8{iw_imm16_val[15]}}, iw_imm16_val} : {8'h00, iw_imm16_val};
  assign op_b    = iw_imm_en ? imm_ext : iw_src_gp_val;
  assign ls_addr = iw_src_ar_val + sext12(iw_imm12_val);
  // Branches see the flags as they stood before this instruction.
  assign cc_ok   = cc_holds(iw_cc, flags_q);

  always_comb begin
    case (iw_opc)
      OP_ADD:  alu_op = ALU_ADD;
      OP_SUB:  alu_op = ALU_SUB;
      OP_CMP:  alu_op = ALU_SUB;
      OP_AND:  alu_op = ALU_AND;
      OP_OR:   alu_op = ALU_OR;
      OP_XOR:  alu_op = ALU_XOR;
      OP_SHL:  alu_op = ALU_SHL;
      OP_SHR:  alu_op = ALU_SHR;
      OP_SAR:  alu_op = ALU_SAR;
      default: alu_op = ALU_MOV;
    endcase
  end

  amber_stg_ex_alu u_alu (
    .op     (alu_op),
    .a      (iw_tgt_gp_val),
    .b      (op_b),
    .result (alu_result),
    .flags  (alu_flags)
  );

  always_comb begin
    nxt        = '0;
    upd_flags  = 1'b0;
    nxt.pc     = iw_pc;
    nxt.instr  = iw_instr;
    nxt.opc    = iw_opc;
    nxt.tgt_gp = iw_tgt_gp;
    nxt.tgt_sr = iw_tgt_sr;
    nxt.tgt_ar = iw_tgt_ar;
    case (iw_opc)
      OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_SAR: begin
        nxt.result    = alu_result;
        nxt.tgt_gp_we = iw_tgt_gp_we;
        upd_flags     = 1'b1;
      end
      OP_CMP: upd_flags = 1'b1;
      OP_LD: begin
        nxt.addr      = ls_addr;
        nxt.tgt_gp_we = iw_tgt_gp_we;
      end
      OP_ST: begin
        nxt.addr   = ls_addr;
        nxt.result = iw_tgt_gp_val;
      end
      OP_ADDA: begin
        nxt.ar_result = iw_tgt_ar_val + sext14(iw_imm14_val);
        nxt.tgt_ar_we = 1'b1;
      end
      OP_MOVA: begin
        nxt.ar_result = iw_src_ar_val;
        nxt.tgt_ar_we = 1'b1;
      end
      OP_SRMOV: begin
        nxt.sr_result = iw_src_sr_val;
        nxt.tgt_sr_we = iw_tgt_sr_we;
      end
      OP_BCC: begin
        nxt.branch_taken = cc_ok;
        nxt.branch_pc    = cc_ok ? (iw_pc + sext16(iw_imm16_val)) : '0;
      end
      OP_JCC: begin
        nxt.branch_taken = cc_ok;
        nxt.branch_pc    = cc_ok ? iw_src_ar_val : '0;
      end
      OP_BAL: begin
        nxt.branch_taken = 1'b1;
        nxt.branch_pc    = iw_pc + sext16(iw_imm16_val);
        nxt.sr_result    = iw_pc + 48'd1;
        nxt.tgt_sr       = SR_LR;
        nxt.tgt_sr_we    = 1'b1;
      end
      OP_SRET: begin
        nxt.branch_taken = 1'b1;
        nxt.branch_pc    = iw_tgt_sr_val;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      out_q   <= '0;
      flags_q <= '0;
    end else if (iw_flush) begin
      out_q <= '0;
    end else if (!iw_stall) begin
      out_q <= nxt;
      if (upd_flags) flags_q <= alu_flags;
    end
  end

  assign ow_pc           = out_q.pc;
  assign ow_instr        = out_q.instr;
  assign ow_opc          = out_q.opc;
  assign ow_tgt_gp       = out_q.tgt_gp;
  assign ow_tgt_gp_we    = out_q.tgt_gp_we;
  assign ow_tgt_sr       = out_q.tgt_sr;
  assign ow_tgt_sr_we    = out_q.tgt_sr_we;
  assign ow_tgt_ar       = out_q.tgt_ar;
  assign ow_tgt_ar_we    = out_q.tgt_ar_we;
  assign ow_addr         = out_q.addr;
  assign ow_result       = out_q.result;
  assign ow_ar_result    = out_q.ar_result;
  assign ow_sr_result    = out_q.sr_result;
  assign ow_branch_taken = out_q.branch_taken;
  assign ow_branch_pc    = out_q.branch_pc;

endmodule

`default_nettype wire

// File: tb/tb_amber_stg_ex.sv
//== tb_amber_stg_ex -- directed vector bench for the Amber execute stage ==
//== rev 1.0                                                             ==
`default_nettype none

module tb_amber_stg_ex;
  import amber_stg_ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] iw_pc, ow_pc, ow_addr, ow_ar_result, ow_sr_result, ow_branch_pc;
  logic [23:0] iw_instr, ow_instr, ow_result;
  logic [7:0]  iw_opc, ow_opc;
  logic        iw_sgn_en, iw_imm_en;
  logic [15:0] iw_imm16_val;
  logic [13:0] iw_imm14_val;
  logic [11:0] iw_imm12_val;
  logic [9:0]  iw_imm10_val;
  logic [3:0]  iw_cc, iw_tgt_gp, iw_src_gp, ow_tgt_gp;
  logic        iw_tgt_gp_we, iw_tgt_sr_we, ow_tgt_gp_we, ow_tgt_sr_we, ow_tgt_ar_we;
  logic [1:0]  iw_tgt_sr, iw_tgt_ar, iw_src_ar, iw_src_sr, ow_tgt_sr, ow_tgt_ar;
  logic [23:0] iw_src_gp_val, iw_tgt_gp_val;
  logic [47:0] iw_src_ar_val, iw_tgt_ar_val, iw_src_sr_val, iw_tgt_sr_val;
  logic        iw_flush, iw_stall, ow_branch_taken;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  amber_stg_ex dut (
    .iw_clk(clk), .iw_rst(rst), .iw_pc(iw_pc), .iw_instr(iw_instr), .iw_opc(iw_opc),
    .iw_sgn_en(iw_sgn_en), .iw_imm_en(iw_imm_en), .iw_imm16_val(iw_imm16_val),
    .iw_imm14_val(iw_imm14_val), .iw_imm12_val(iw_imm12_val), .iw_imm10_val(iw_imm10_val),
    .iw_cc(iw_cc), .iw_tgt_gp(iw_tgt_gp), .iw_tgt_gp_we(iw_tgt_gp_we),
    .iw_tgt_sr(iw_tgt_sr), .iw_tgt_sr_we(iw_tgt_sr_we), .iw_tgt_ar(iw_tgt_ar),
    .iw_src_gp(iw_src_gp), .iw_src_ar(iw_src_ar), .iw_src_sr(iw_src_sr),
    .iw_src_gp_val(iw_src_gp_val), .iw_tgt_gp_val(iw_tgt_gp_val),
    .iw_src_ar_val(iw_src_ar_val), .iw_tgt_ar_val(iw_tgt_ar_val),
    .iw_src_sr_val(iw_src_sr_val), .iw_tgt_sr_val(iw_tgt_sr_val),
    .iw_flush(iw_flush), .iw_stall(iw_stall),
    .ow_pc(ow_pc), .ow_instr(ow_instr), .ow_opc(ow_opc),
    .ow_tgt_gp(ow_tgt_gp), .ow_tgt_gp_we(ow_tgt_gp_we),
    .ow_tgt_sr(ow_tgt_sr), .ow_tgt_sr_we(ow_tgt_sr_we),
    .ow_tgt_ar(ow_tgt_ar), .ow_tgt_ar_we(ow_tgt_ar_we),
    .ow_addr(ow_addr), .ow_result(ow_result), .ow_ar_result(ow_ar_result),
    .ow_sr_result(ow_sr_result), .ow_branch_taken(ow_branch_taken),
    .ow_branch_pc(ow_branch_pc)
  );

  typedef struct {
    logic [7:0]  opc;
    logic        sgn, imm_en, gwe_in, swe_in;
    logic [15:0] imm;
    logic [3:0]  cc;
    logic [47:0] pc, sar, tar, ssr, tsr;
    logic [23:0] a, b;
    logic [23:0] e_res;
    logic [47:0] e_addr, e_ar, e_sr, e_bpc;
    logic        e_tk, e_gwe, e_awe, e_swe;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t blank();
    vec_t t;
    t.opc = '0; t.sgn = 1'b0; t.imm_en = 1'b0; t.gwe_in = 1'b0; t.swe_in = 1'b0;
    t.imm = '0; t.cc = '0; t.pc = '0; t.sar = '0; t.tar = '0; t.ssr = '0; t.tsr = '0;
    t.a = '0; t.b = '0; t.e_res = '0; t.e_addr = '0; t.e_ar = '0; t.e_sr = '0;
    t.e_bpc = '0; t.e_tk = 1'b0; t.e_gwe = 1'b0; t.e_awe = 1'b0; t.e_swe = 1'b0;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t t, input logic fl, input logic st, input logic [23:0] instr);
    iw_opc = t.opc; iw_sgn_en = t.sgn; iw_imm_en = t.imm_en;
    iw_imm16_val = t.imm; iw_imm14_val = t.imm[13:0];
    iw_imm12_val = t.imm[11:0]; iw_imm10_val = t.imm[9:0];
    iw_cc = t.cc; iw_pc = t.pc; iw_instr = instr;
    iw_tgt_gp = 4'h3; iw_tgt_gp_we = t.gwe_in; iw_tgt_sr = 2'd2; iw_tgt_sr_we = t.swe_in;
    iw_tgt_ar = 2'd1; iw_src_gp = 4'h5; iw_src_ar = 2'd2; iw_src_sr = 2'd3;
    iw_tgt_gp_val = t.a; iw_src_gp_val = t.b; iw_src_ar_val = t.sar;
    iw_tgt_ar_val = t.tar; iw_src_sr_val = t.ssr; iw_tgt_sr_val = t.tsr;
    iw_flush = fl; iw_stall = st;
  endtask

  task automatic check_vec(input vec_t t, input int i);
    chk($sformatf("v%0d.opc", i),   64'(ow_opc),          64'(t.opc));
    chk($sformatf("v%0d.pc", i),    64'(ow_pc),           64'(t.pc));
    chk($sformatf("v%0d.instr", i), 64'(ow_instr),        64'(i));
    chk($sformatf("v%0d.res", i),   64'(ow_result),       64'(t.e_res));
    chk($sformatf("v%0d.addr", i),  64'(ow_addr),         64'(t.e_addr));
    chk($sformatf("v%0d.ar", i),    64'(ow_ar_result),    64'(t.e_ar));
    chk($sformatf("v%0d.sr", i),    64'(ow_sr_result),    64'(t.e_sr));
    chk($sformatf("v%0d.tk", i),    64'(ow_branch_taken), 64'(t.e_tk));
    chk($sformatf("v%0d.bpc", i),   64'(ow_branch_pc),    64'(t.e_bpc));
    chk($sformatf("v%0d.gwe", i),   64'(ow_tgt_gp_we),    64'(t.e_gwe));
    chk($sformatf("v%0d.awe", i),   64'(ow_tgt_ar_we),    64'(t.e_awe));
    chk($sformatf("v%0d.swe", i),   64'(ow_tgt_sr_we),    64'(t.e_swe));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t t;
    // Flags: after ADD Z=1 C=1
    t = blank(); t.opc = OP_ADD; t.a = 24'hFFFFFF; t.b = 24'h1; t.gwe_in = 1; t.e_gwe = 1; tbl.push_back(t);
    t = blank(); t.opc = OP_BCC; t.cc = CC_EQ; t.pc = 48'h200; t.imm = 16'h0010; t.e_tk = 1; t.e_bpc = 48'h210; tbl.push_back(t);
    t = blank(); t.opc = OP_BCC; t.cc = CC_LTU; t.pc = 48'h200; t.imm = 16'hFFF0; t.e_tk = 1; t.e_bpc = 48'h1F0; tbl.push_back(t);
    t = blank(); t.opc = OP_BCC; t.cc = CC_NE; t.pc = 48'h200; t.imm = 16'h0004; tbl.push_back(t);
    t = blank(); t.opc = OP_BCC; t.cc = 4'hF; t.pc = 48'h200; t.imm = 16'h0004; tbl.push_back(t);
    t = blank(); t.opc = OP_LD; t.sar = 48'h1000; t.imm = 16'h0FFF; t.sgn = 1; t.gwe_in = 1; t.e_addr = 48'hFFF; t.e_gwe = 1; tbl.push_back(t);
    t = blank(); t.opc = OP_ST; t.sar = 48'h2000; t.imm = 16'h0010; t.a = 24'h123456; t.gwe_in = 1; t.e_addr = 48'h2010; t.e_res = 24'h123456; tbl.push_back(t);
    // SUB 5-7: N=1 C(borrow)=1 V=0
    t = blank(); t.opc = OP_SUB; t.a = 24'd5; t.b = 24'd7; t.gwe_in = 1; t.e_res = 24'hFFFFFE; t.e_gwe = 1; tbl.push_back(t);
    t = blank(); t.opc = OP_BCC; t.cc = CC_LT; t.pc = 48'h300; t.imm = 16'h0004; t.e_tk = 1; t.e_bpc = 48'h304; tbl.push_back(t);
    // CMP equal: Z=1 C=0, no GP write
    t = blank(); t.opc = OP_CMP; t.a = 24'd7; t.imm_en = 1; t.imm = 16'd7; t.gwe_in = 1; tbl.push_back(t);
    t = blank(); t.opc = OP_BCC; t.cc = CC_GEU; t.pc = 48'h400; t.imm = 16'h0008; t.e_tk = 1; t.e_bpc = 48'h408; tbl.push_back(t);
    t = blank(); t.opc = OP_JCC; t.cc = CC_EQ; t.sar = 48'hABCDEF123456; t.e_tk = 1; t.e_bpc = 48'hABCDEF123456; tbl.push_back(t);
    t = blank(); t.opc = OP_JCC; t.cc = CC_NE; t.sar = 48'h1; tbl.push_back(t);
    t = blank(); t.opc = OP_AND; t.a = 24'hF0F0F0; t.imm_en = 1; t.sgn = 1; t.imm = 16'hFF0F; t.gwe_in = 1; t.e_res = 24'hF0F000; t.e_gwe = 1; tbl.push_back(t);
    t = blank(); t.opc = OP_OR; t.a = 24'h000F00; t.imm_en = 1; t.imm = 16'h8001; t.gwe_in = 1; t.e_res = 24'h008F01; t.e_gwe = 1; tbl.push_back(t);
    t = blank(); t.opc = OP_XOR; t.a = 24'hAAAAAA; t.b = 24'hFFFFFF; t.e_res = 24'h555555; tbl.push_back(t);
    t = blank(); t.opc = OP_SHL; t.a = 24'h1; t.b = 24'd23; t.e_res = 24'h800000; tbl.push_back(t);
    t = blank(); t.opc = OP_SHL; t.a = 24'h1; t.b = 24'd24; t.e_res = 24'h0; tbl.push_back(t);
    t = blank(); t.opc = OP_SAR; t.a = 24'h800000; t.b = 24'd4; t.e_res = 24'hF80000; tbl.push_back(t);
    t = blank(); t.opc = OP_SAR; t.a = 24'h800000; t.b = 24'd30; t.e_res = 24'hFFFFFF; tbl.push_back(t);
    t = blank(); t.opc = OP_SHR; t.a = 24'h800000; t.b = 24'd4; t.e_res = 24'h080000; tbl.push_back(t);
    t = blank(); t.opc = OP_SHR; t.a = 24'h800000; t.b = 24'd24; t.e_res = 24'h0; tbl.push_back(t);
    // Signed overflow: N=1 V=1 so GE holds and LT does not
    t = blank(); t.opc = OP_ADD; t.a = 24'h7FFFFF; t.b = 24'h1; t.e_res = 24'h800000; tbl.push_back(t);
    t = blank(); t.opc = OP_BCC; t.cc = CC_GE; t.pc = 48'h500; t.e_tk = 1; t.e_bpc = 48'h500; tbl.push_back(t);
    t = blank(); t.opc = OP_BCC; t.cc = CC_LT; t.pc = 48'h500; tbl.push_back(t);
    t = blank(); t.opc = OP_MOV; t.imm_en = 1; t.sgn = 1; t.imm = 16'h8000; t.gwe_in = 1; t.e_res = 24'hFF8000; t.e_gwe = 1; tbl.push_back(t);
    t = blank(); t.opc = OP_ADDA; t.tar = 48'h1000; t.imm = 16'h3FFF; t.e_ar = 48'hFFF; t.e_awe = 1; tbl.push_back(t);
    t = blank(); t.opc = OP_MOVA; t.sar = 48'h123456789ABC; t.e_ar = 48'h123456789ABC; t.e_awe = 1; tbl.push_back(t);
    t = blank(); t.opc = OP_SRMOV; t.ssr = 48'hDEADBEEF; t.swe_in = 1; t.e_sr = 48'hDEADBEEF; t.e_swe = 1; tbl.push_back(t);
    t = blank(); t.opc = OP_BAL; t.pc = 48'h600; t.imm = 16'h0100; t.e_tk = 1; t.e_bpc = 48'h700; t.e_sr = 48'h601; t.e_swe = 1; tbl.push_back(t);
    t = blank(); t.opc = 8'hEE; t.gwe_in = 1; t.swe_in = 1; t.a = 24'h1; t.b = 24'h2; tbl.push_back(t);
    t = blank(); t.opc = OP_SRET; t.tsr = 48'hFEDCBA987654; t.e_tk = 1; t.e_bpc = 48'hFEDCBA987654; tbl.push_back(t);

    // Reset held with an SRET presented
    rst = 1'b1;
    t = blank(); t.opc = OP_SRET; t.pc = 48'h123; t.tsr = 48'h000000ABCDEF0;
    drive(t, 1'b0, 1'b0, 24'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.tk",  64'(ow_branch_taken), 64'd0);
    chk("rst.bpc", 64'(ow_branch_pc),    64'd0);
    chk("rst.pc",  64'(ow_pc),           64'd0);
    chk("rst.opc", 64'(ow_opc),          64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("sret.tk",  64'(ow_branch_taken), 64'd1);
    chk("sret.bpc", 64'(ow_branch_pc),    64'h000000ABCDEF0);
    chk("sret.opc", 64'(ow_opc),          64'(OP_SRET));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i], 1'b0, 1'b0, 24'(i));
      step();
      check_vec(tbl[i], i);
    end

    // Flush turns a taken SRET into a bubble
    t = blank(); t.opc = OP_SRET; t.tsr = 48'h111; t.pc = 48'h40;
    drive(t, 1'b1, 1'b0, 24'h0);
    step();
    chk("flush.tk",  64'(ow_branch_taken), 64'd0);
    chk("flush.opc", 64'(ow_opc),          64'(OP_NOP));
    chk("flush.bpc", 64'(ow_branch_pc),    64'd0);
    chk("flush.pc",  64'(ow_pc),           64'd0);

    // Stall holds a taken branch
    t = blank(); t.opc = OP_SRET; t.tsr = 48'h222; t.pc = 48'h44;
    drive(t, 1'b0, 1'b0, 24'h0);
    step();
    chk("pre_stall.tk", 64'(ow_branch_taken), 64'd1);
    t = blank(); t.opc = OP_ADD; t.a = 24'h5; t.b = 24'h6; t.gwe_in = 1; t.pc = 48'h999;
    drive(t, 1'b0, 1'b1, 24'h0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("stall%0d.tk", k),  64'(ow_branch_taken), 64'd1);
      chk($sformatf("stall%0d.bpc", k), 64'(ow_branch_pc),    64'h222);
      chk($sformatf("stall%0d.opc", k), 64'(ow_opc),          64'(OP_SRET));
      chk($sformatf("stall%0d.pc", k),  64'(ow_pc),           64'h44);
    end

    // Flags must survive a flushed and a stalled CMP that would clear Z
    t = blank(); t.opc = OP_CMP; t.a = 24'h1; t.b = 24'h1;
    drive(t, 1'b0, 1'b0, 24'h0);
    step();
    t.b = 24'h2;
    drive(t, 1'b1, 1'b0, 24'h0);
    step();
    drive(t, 1'b0, 1'b1, 24'h0);
    step();
    t = blank(); t.opc = OP_BCC; t.cc = CC_EQ; t.pc = 48'h800; t.imm = 16'h0002;
    drive(t, 1'b0, 1'b0, 24'h0);
    step();
    chk("hold_flags.tk",  64'(ow_branch_taken), 64'd1);
    chk("hold_flags.bpc", 64'(ow_branch_pc),    64'h802);

    // Reset acts without waiting for a clock edge
    #2 rst = 1'b1;
    #1;
    chk("async_rst.tk",  64'(ow_branch_taken), 64'd0);
    chk("async_rst.bpc", 64'(ow_branch_pc),    64'd0);
    step();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
